// File: rtl/cdma_rd_splitter_pkg.sv
// Shared types and constants for the CDMA read splitter.
// The optional statistics counters are enabled with the CDMA_RD_SPLIT_STATS_EN macro.
package cdma_rd_splitter_pkg;

    localparam int HBM_ADDR_BITS = 34;
    localparam int HBM_LEN_BITS  = 32;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SPLIT = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    typedef struct packed {
        logic [HBM_ADDR_BITS-1:0] paddr;
        logic [HBM_LEN_BITS-1:0]  len;
    } rd_req_t;

endpackage

// File: rtl/cdma_rd_chunk_calc.sv
// Combinational chunk sizing: the largest piece of the remaining request that
// stays inside the current 2**CHUNK_BITS-byte window.
module cdma_rd_chunk_calc
    import cdma_rd_splitter_pkg::*;
#(
    parameter int LEN_BITS   = HBM_LEN_BITS,
    parameter int CHUNK_BITS = 12
) (
    input  logic [CHUNK_BITS-1:0] addr_low,
    input  logic [LEN_BITS-1:0]   remaining,
    output logic [LEN_BITS-1:0]   chunk_len,
    output logic                  last
);

    logic [CHUNK_BITS:0] space;
    logic [LEN_BITS-1:0] space_len;

    // Bytes left before the next boundary; a full window when addr_low is zero.
    assign space     = {1'b1, {CHUNK_BITS{1'b0}}} - {1'b0, addr_low};
    assign space_len = LEN_BITS'(space);
    assign last      = (remaining <= space_len);
    assign chunk_len = last ? remaining : space_len;

endmodule

// File: rtl/cdma_rd_splitter.sv
// Splits large read requests into boundary-aligned chunks for the CDMA read port.
// Define CDMA_RD_SPLIT_STATS_EN to add the stat_chunks / stat_stall counters.
module cdma_rd_splitter
    import cdma_rd_splitter_pkg::*;
#(
    parameter int ADDR_BITS       = HBM_ADDR_BITS,
    parameter int LEN_BITS        = HBM_LEN_BITS,
    parameter int CHUNK_BITS      = 12,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 s_req_valid,
    output logic                 s_req_ready,
    input  logic [ADDR_BITS-1:0] s_req_paddr,
    input  logic [LEN_BITS-1:0]  s_req_len,
    output logic                 s_req_done,
    output logic                 m_rd_valid,
    input  logic                 m_rd_ready,
    output logic [ADDR_BITS-1:0] m_rd_paddr,
    output logic [LEN_BITS-1:0]  m_rd_len,
    input  logic                 m_rd_done
`ifdef CDMA_RD_SPLIT_STATS_EN
    ,
    output logic [31:0]          stat_chunks,
    output logic [31:0]          stat_stall
`endif
);

    localparam int OUT_BITS = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_BITS-1:0] OUT_MAX = OUT_BITS'(MAX_OUTSTANDING);

    logic [1:0]           state, state_nxt;
    logic [ADDR_BITS-1:0] nxt_addr, calc_addr;
    logic [LEN_BITS-1:0]  nxt_rem, calc_rem, chunk_len;
    logic                 calc_last, cur_last;
    logic [OUT_BITS-1:0]  outstanding, out_nxt;
    logic                 accept, issue, done_ok, load, valid_nxt;

    assign accept    = s_req_valid & s_req_ready;
    assign issue     = m_rd_valid & m_rd_ready;
    assign done_ok   = m_rd_done & (outstanding != '0);
    // The first chunk is sized straight from the request so it can be presented the cycle after accept.
    assign calc_addr = (state == IDLE) ? s_req_paddr : nxt_addr;
    assign calc_rem  = (state == IDLE) ? s_req_len : nxt_rem;

    cdma_rd_chunk_calc #(
        .LEN_BITS   (LEN_BITS),
        .CHUNK_BITS (CHUNK_BITS)
    ) u_chunk_calc (
        .addr_low  (calc_addr[CHUNK_BITS-1:0]),
        .remaining (calc_rem),
        .chunk_len (chunk_len),
        .last      (calc_last)
    );

    always_comb begin
        out_nxt = outstanding;
        if (issue && !done_ok) begin
            out_nxt = outstanding + OUT_BITS'(1);
        end else if (!issue && done_ok) begin
            out_nxt = outstanding - OUT_BITS'(1);
        end
    end

    // A presented chunk stays valid until taken; a new one only appears below the in-flight cap.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        valid_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (s_req_len == '0) begin
                        state_nxt = DRAIN;
                    end else begin
                        state_nxt = SPLIT;
                        load      = 1'b1;
                        valid_nxt = (out_nxt != OUT_MAX);
                    end
                end
            end
            SPLIT: begin
                if (issue && cur_last) begin
                    state_nxt = DRAIN;
                end else if (issue) begin
                    load      = 1'b1;
                    valid_nxt = (out_nxt != OUT_MAX);
                end else begin
                    valid_nxt = m_rd_valid | (out_nxt != OUT_MAX);
                end
            end
            DRAIN: begin
                if (out_nxt == '0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state       <= IDLE;
            outstanding <= '0;
            s_req_ready <= 1'b0;
            s_req_done  <= 1'b0;
            m_rd_valid  <= 1'b0;
            m_rd_paddr  <= '0;
            m_rd_len    <= '0;
            nxt_addr    <= '0;
            nxt_rem     <= '0;
            cur_last    <= 1'b0;
        end else begin
            state       <= state_nxt;
            outstanding <= out_nxt;
            s_req_ready <= (state_nxt == IDLE);
            s_req_done  <= (state == DRAIN) && (out_nxt == '0);
            m_rd_valid  <= valid_nxt;
            if (load) begin
                m_rd_paddr <= calc_addr;
                m_rd_len   <= chunk_len;
                cur_last   <= calc_last;
                nxt_addr   <= calc_addr + ADDR_BITS'(chunk_len);
                nxt_rem    <= calc_rem - chunk_len;
            end
        end
    end

`ifdef CDMA_RD_SPLIT_STATS_EN
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            stat_chunks <= '0;
            stat_stall  <= '0;
        end else begin
            if (issue && (stat_chunks != '1)) begin
                stat_chunks <= stat_chunks + 32'd1;
            end
            if ((state == SPLIT) && (outstanding == OUT_MAX) && (stat_stall != '1)) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cdma_rd_splitter.sv
// Directed bench for cdma_rd_splitter with CHUNK_BITS=12 and MAX_OUTSTANDING=4.
// A negedge monitor records issued chunks and returns rd_done five cycles after issue.
module tb_cdma_rd_splitter;
    import cdma_rd_splitter_pkg::*;

    localparam int ADDR_BITS = HBM_ADDR_BITS;
    localparam int LEN_BITS  = HBM_LEN_BITS;

    logic                 aclk;
    logic                 areset;
    logic                 s_req_valid;
    logic                 s_req_ready;
    logic [ADDR_BITS-1:0] s_req_paddr;
    logic [LEN_BITS-1:0]  s_req_len;
    logic                 s_req_done;
    logic                 m_rd_valid;
    logic                 m_rd_ready;
    logic [ADDR_BITS-1:0] m_rd_paddr;
    logic [LEN_BITS-1:0]  m_rd_len;
    logic                 m_rd_done;
`ifdef CDMA_RD_SPLIT_STATS_EN
    logic [31:0]          stat_chunks;
    logic [31:0]          stat_stall;
`endif

    logic    auto_done = 1'b0;
    logic    man_done  = 1'b0;
    logic    auto_en   = 1'b1;
    int      vectors     = 0;
    int      miscompares = 0;
    int      cyc         = 0;
    int      sdone_cnt   = 0;
    int      sdone_cyc   = 0;
    int      done_cyc    = 0;
    int      age_q[$];
    rd_req_t chunk_q[$];

    assign m_rd_done = auto_done | man_done;

    cdma_rd_splitter #(
        .ADDR_BITS       (ADDR_BITS),
        .LEN_BITS        (LEN_BITS),
        .CHUNK_BITS      (12),
        .MAX_OUTSTANDING (4)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .s_req_valid (s_req_valid),
        .s_req_ready (s_req_ready),
        .s_req_paddr (s_req_paddr),
        .s_req_len   (s_req_len),
        .s_req_done  (s_req_done),
        .m_rd_valid  (m_rd_valid),
        .m_rd_ready  (m_rd_ready),
        .m_rd_paddr  (m_rd_paddr),
        .m_rd_len    (m_rd_len),
        .m_rd_done   (m_rd_done)
`ifdef CDMA_RD_SPLIT_STATS_EN
        ,
        .stat_chunks (stat_chunks),
        .stat_stall  (stat_stall)
`endif
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Negedge monitor: everything seen here is what the next rising edge samples.
    initial begin
        forever begin
            @(negedge aclk);
            cyc++;
            if (areset) begin
                age_q.delete();
                auto_done = 1'b0;
            end else begin
                foreach (age_q[i]) age_q[i]++;
                auto_done = auto_en && (age_q.size() > 0) && (age_q[0] >= 5);
                if (auto_done || man_done) begin
                    if (age_q.size() > 0) void'(age_q.pop_front());
                    done_cyc = cyc;
                end
                if (m_rd_valid && m_rd_ready) begin
                    age_q.push_back(0);
                    chunk_q.push_back('{paddr: m_rd_paddr, len: m_rd_len});
                end
                if (s_req_done) begin
                    sdone_cnt++;
                    sdone_cyc = cyc;
                end
            end
        end
    end

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [ADDR_BITS-1:0] paddr, input logic [LEN_BITS-1:0] len);
        int n = 0;
        s_req_valid = 1'b1;
        s_req_paddr = paddr;
        s_req_len   = len;
        while (!s_req_ready && n < 20) begin
            tick(1);
            n++;
        end
        if (!s_req_ready) check_output("req_accept_timeout", 64'(s_req_ready), 64'd1);
        tick(1);
        s_req_valid = 1'b0;
    endtask

    task automatic wait_sdone(input string tag, input int base, input int budget);
        int n = 0;
        while (sdone_cnt == base && n < budget) begin
            tick(1);
            n++;
        end
        check_output(tag, 64'(sdone_cnt != base), 64'd1);
    endtask

    task automatic check_chunk(input string tag, input int idx, input logic [63:0] paddr, input logic [63:0] len);
        if (chunk_q.size() > idx) begin
            check_output({tag, "_paddr"}, 64'(chunk_q[idx].paddr), paddr);
            check_output({tag, "_len"}, 64'(chunk_q[idx].len), len);
        end else begin
            check_output({tag, "_missing"}, 64'(chunk_q.size()), 64'(idx + 1));
        end
    endtask

    initial begin
        int base;
        areset      = 1'b1;
        s_req_valid = 1'b0;
        s_req_paddr = '0;
        s_req_len   = '0;
        m_rd_ready  = 1'b1;

        #1;
        check_output("rst_ready", 64'(s_req_ready), 64'd0);
        check_output("rst_done", 64'(s_req_done), 64'd0);
        check_output("rst_valid", 64'(m_rd_valid), 64'd0);
        check_output("rst_paddr", 64'(m_rd_paddr), 64'd0);
        check_output("rst_len", 64'(m_rd_len), 64'd0);
        tick(2);
        check_output("rst_ready_held", 64'(s_req_ready), 64'd0);
        areset = 1'b0;
        tick(1);
        check_output("rst_ready_rise", 64'(s_req_ready), 64'd1);

        // Aligned 12 KB request: three full chunks
        chunk_q.delete();
        base = sdone_cnt;
        apply_stimulus(34'h0000, 32'h3000);
        check_output("t1_first_valid", 64'(m_rd_valid), 64'd1);
        check_output("t1_ready_low", 64'(s_req_ready), 64'd0);
        wait_sdone("t1_done_seen", base, 60);
        tick(3);
        check_output("t1_chunk_count", 64'(chunk_q.size()), 64'd3);
        check_chunk("t1_c0", 0, 64'h0000, 64'h1000);
        check_chunk("t1_c1", 1, 64'h1000, 64'h1000);
        check_chunk("t1_c2", 2, 64'h2000, 64'h1000);
        check_output("t1_done_once", 64'(sdone_cnt - base), 64'd1);
        check_output("t1_done_latency", 64'(sdone_cyc - done_cyc), 64'd1);

        // Request straddling a 4 KB boundary
        chunk_q.delete();
        base = sdone_cnt;
        apply_stimulus(34'h0F40, 32'h0200);
        wait_sdone("t2_done_seen", base, 60);
        tick(3);
        check_output("t2_chunk_count", 64'(chunk_q.size()), 64'd2);
        check_chunk("t2_c0", 0, 64'h0F40, 64'h00C0);
        check_chunk("t2_c1", 1, 64'h1000, 64'h0140);
        check_output("t2_done_once", 64'(sdone_cnt - base), 64'd1);

        // Zero-length request
        chunk_q.delete();
        base = sdone_cnt;
        apply_stimulus(34'h1234, 32'h0);
        check_output("t4_valid_t1", 64'(m_rd_valid), 64'd0);
        check_output("t4_ready_t1", 64'(s_req_ready), 64'd0);
        check_output("t4_done_t1", 64'(s_req_done), 64'd0);
        tick(1);
        check_output("t4_done_t2", 64'(s_req_done), 64'd1);
        check_output("t4_ready_t2", 64'(s_req_ready), 64'd1);
        check_output("t4_valid_t2", 64'(m_rd_valid), 64'd0);
        tick(1);
        check_output("t4_done_pulse", 64'(s_req_done), 64'd0);
        check_output("t4_no_chunks", 64'(chunk_q.size()), 64'd0);

        // Throttle at four outstanding with rd_done withheld
        chunk_q.delete();
        base = sdone_cnt;
        auto_en = 1'b0;
        apply_stimulus(34'h0000, 32'h8000);
        tick(10);
        check_output("t3_capped_count", 64'(chunk_q.size()), 64'd4);
        check_output("t3_capped_valid", 64'(m_rd_valid), 64'd0);
        man_done = 1'b1;
        tick(1);
        man_done = 1'b0;
        check_output("t3_resume_valid", 64'(m_rd_valid), 64'd1);
        check_output("t3_resume_paddr", 64'(m_rd_paddr), 64'h4000);
        check_output("t3_resume_len", 64'(m_rd_len), 64'h1000);
        tick(1);
        check_output("t3_fifth_count", 64'(chunk_q.size()), 64'd5);
        check_chunk("t3_c4", 4, 64'h4000, 64'h1000);
        auto_en = 1'b1;
        wait_sdone("t3_done_seen", base, 120);
        tick(3);
        check_output("t3_total_chunks", 64'(chunk_q.size()), 64'd8);
        check_chunk("t3_c7", 7, 64'h7000, 64'h1000);
        check_output("t3_done_once", 64'(sdone_cnt - base), 64'd1);

        // Back-pressure hold, then issue and rd_done in the same cycle
        chunk_q.delete();
        base = sdone_cnt;
        auto_en = 1'b0;
        m_rd_ready = 1'b0;
        apply_stimulus(34'h0000, 32'h2000);
        for (int i = 0; i < 10; i++) begin
            check_output("t5_hold_valid", 64'(m_rd_valid), 64'd1);
            check_output("t5_hold_paddr", 64'(m_rd_paddr), 64'h0000);
            check_output("t5_hold_len", 64'(m_rd_len), 64'h1000);
            tick(1);
        end
        m_rd_ready = 1'b1;
        tick(1);
        m_rd_ready = 1'b0;
        check_output("t5_c1_valid", 64'(m_rd_valid), 64'd1);
        check_output("t5_c1_paddr", 64'(m_rd_paddr), 64'h1000);
        tick(2);
        m_rd_ready = 1'b1;
        man_done = 1'b1;
        tick(1);
        man_done = 1'b0;
        tick(2);
        check_output("t5_no_early_done", 64'(sdone_cnt - base), 64'd0);
        man_done = 1'b1;
        tick(1);
        man_done = 1'b0;
        check_output("t5_done_after_last", 64'(s_req_done), 64'd1);
        check_output("t5_chunk_count", 64'(chunk_q.size()), 64'd2);
        tick(2);
        auto_en = 1'b1;

        // Reset in the middle of a split, then a stray rd_done and a fresh request
        chunk_q.delete();
        apply_stimulus(34'h0000, 32'h8000);
        tick(3);
        base = sdone_cnt;
        areset = 1'b1;
        #1;
        check_output("t6_rst_valid", 64'(m_rd_valid), 64'd0);
        check_output("t6_rst_paddr", 64'(m_rd_paddr), 64'd0);
        check_output("t6_rst_len", 64'(m_rd_len), 64'd0);
        check_output("t6_rst_ready", 64'(s_req_ready), 64'd0);
        check_output("t6_rst_done", 64'(s_req_done), 64'd0);
        tick(2);
        areset = 1'b0;
        auto_en = 1'b0;
        man_done = 1'b1;
        tick(1);
        man_done = 1'b0;
        check_output("t6_ready_after_rst", 64'(s_req_ready), 64'd1);
        tick(8);
        check_output("t6_no_aborted_done", 64'(sdone_cnt - base), 64'd0);
        auto_en = 1'b1;
        chunk_q.delete();
        apply_stimulus(34'h2000, 32'h1000);
        wait_sdone("t6_done_seen", base, 60);
        tick(3);
        check_output("t6_chunk_count", 64'(chunk_q.size()), 64'd1);
        check_chunk("t6_c0", 0, 64'h2000, 64'h1000);
        check_output("t6_done_once", 64'(sdone_cnt - base), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
